tinyodin_obi_loader: RTL and testbench
======================================

TINYODIN_OBI_LOADER -- requirements
Module: tinyodin_obi_loader

Interface
REQ-001 SHALL have parameter req_t, default logic, meaning the OBI request type (req, we, be, addr, wdata).
REQ-002 SHALL have parameter rsp_t, default logic, meaning the OBI response type (gnt, rvalid, rdata).
REQ-003 SHALL have parameter LEN_W, default 16, meaning the word-count width.
REQ-004 SHALL have port CLK  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port RSTN  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start_i  input  1  one-cycle start pulse, sampled only in IDLE.
REQ-007 SHALL have port src_addr_i  input  32  word-aligned source base address.
REQ-008 SHALL have port dst_addr_i  input  32  word-aligned destination base address in the tinyODIN slave window.
REQ-009 SHALL have port len_i  input  LEN_W  number of 32-bit words to copy.
REQ-010 SHALL have port abort_i  input  1  request early termination.
REQ-011 SHALL have port loader_master_req_o  output  req_t  OBI initiator request.
REQ-012 SHALL have port loader_master_resp_i  input  rsp_t  OBI initiator response.
REQ-013 SHALL have port busy_o  output  1  high from the cycle after accepted start until DONE.
REQ-014 SHALL have port intr_loader_done_o  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL latch src_addr_i, dst_addr_i, len_i on start_i in IDLE; inputs ignored otherwise.
REQ-016 SHALL implement FSM IDLE -> RD_REQ -> RD_WAIT -> WR_REQ -> WR_WAIT -> (RD_REQ if words remain, else DONE) -> IDLE.
REQ-017 SHALL go IDLE -> DONE directly when start_i arrives with len_i = 0; no OBI traffic.
REQ-018 SHALL in RD_REQ drive req=1, we=0, be=4'hF, addr=current src; move to RD_WAIT on the gnt cycle.
REQ-019 SHALL in RD_WAIT capture rdata into a one-word buffer on rvalid, then move to WR_REQ.
REQ-020 SHALL in WR_REQ drive req=1, we=1, be=4'hF, addr=current dst, wdata=buffer; move to WR_WAIT on gnt.
REQ-021 SHALL in WR_WAIT on rvalid add 4 to src and dst, decrement remaining count.
REQ-022 SHALL hold req, we, addr, wdata stable from req assertion until gnt; req deasserted in all other states.
REQ-023 SHALL have at most one outstanding transaction; rvalid outside RD_WAIT/WR_WAIT ignored.
REQ-024 SHALL wrap addresses modulo 2^32 without error.
REQ-025 SHALL pulse intr_loader_done_o for exactly one cycle in DONE, busy_o low in that cycle.
REQ-026 SHALL ignore start_i while busy_o is high.

Reset
REQ-027 SHALL on RSTN low immediately enter IDLE, clear counters, buffer, latched addresses; req=0, we=0, be=0, addr=0, wdata=0, busy_o=0, intr_loader_done_o=0.
REQ-028 SHALL, when reset mid-transfer, issue no further requests and produce no done pulse for the aborted transfer.

Configuration
REQ-029 SHALL support macro TINYODIN_LOADER_ABORT_EN.
REQ-030 SHALL with TINYODIN_LOADER_ABORT_EN defined: abort_i sampled in any non-IDLE state; in RD_REQ/WR_REQ before gnt go to DONE immediately; in RD_WAIT/WR_WAIT finish the pending rvalid, then DONE; done pulse still issued.
REQ-031 SHALL without TINYODIN_LOADER_ABORT_EN: abort_i ignored, transfer always runs to len words.

Structure
REQ-032 SHALL place the FSM state enum, LEN_W default and OBI word constants (BE_FULL=4'hF, WORD_BYTES=4) in package tinyodin_loader_pkg.
REQ-033 SHALL place src/dst address increment and remaining-count logic in one sub-module tinyodin_loader_ctr.

Verification
REQ-034 SHALL cover: src=0x1000, dst=0x2000_0100, len=3, gnt same cycle, rvalid next cycle -> reads 0x1000/04/08, writes 0x2000_0100/04/08 with read data, done after 12 transaction cycles + DONE.
REQ-035 SHALL cover: len=0 -> no req, intr_loader_done_o pulse one cycle after start.
REQ-036 SHALL cover: gnt delayed 5 cycles on first write -> addr/wdata/we stable all 5 cycles, single write issued.
REQ-037 SHALL cover: start_i pulsed while busy -> ignored, original len completes unchanged.
REQ-038 SHALL cover: RSTN low during WR_WAIT of word 2 of 4 -> outputs at reset values, no done pulse, new start works.
REQ-039 SHALL cover (ABORT_EN): abort_i in RD_WAIT of word 1 of 8 -> rvalid consumed, no write, done pulse, busy_o low.

Source files
------------

// File: rtl/tinyodin_loader_pkg.sv
// Shared types and constants for the tinyODIN OBI loader.
// Bus structs define the bit layout that the loader's req_t/rsp_t parameters must follow.
package tinyodin_loader_pkg;

    localparam int unsigned LEN_W_DEFAULT = 16;
    localparam logic [3:0]  BE_FULL       = 4'hF;
    localparam int unsigned WORD_BYTES    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_DONE
    } loader_state_e;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_rsp_t;

endpackage

// File: rtl/tinyodin_loader_ctr.sv
// Source/destination address walkers and remaining-word down-counter for the loader.
// Addresses wrap modulo 2^32; last_word flags the terminal count before the final step.
module tinyodin_loader_ctr
    import tinyodin_loader_pkg::*;
#(
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             step,
    input  logic [31:0]      src_base,
    input  logic [31:0]      dst_base,
    input  logic [LEN_W-1:0] len,
    output logic [31:0]      src_addr,
    output logic [31:0]      dst_addr,
    output logic             last_word
);

    logic [LEN_W-1:0] remaining;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_addr  <= '0;
            dst_addr  <= '0;
            remaining <= '0;
        end else if (load) begin
            src_addr  <= src_base;
            dst_addr  <= dst_base;
            remaining <= len;
        end else if (step) begin
            src_addr  <= src_addr + 32'(WORD_BYTES);
            dst_addr  <= dst_addr + 32'(WORD_BYTES);
            remaining <= remaining - LEN_W'(1);
        end
    end

    assign last_word = (remaining == LEN_W'(1));

endmodule

// File: rtl/tinyodin_obi_loader.sv
// tinyODIN OBI loader: copies len_i words from src to dst, one OBI transaction at a time.
// Optional early termination is built in when TINYODIN_LOADER_ABORT_EN is defined.
//
// state    | meaning
// IDLE     | waiting for start_i
// RD_REQ   | read request on the bus until gnt
// RD_WAIT  | read granted, waiting for rvalid to fill the buffer
// WR_REQ   | write of the buffered word on the bus until gnt
// WR_WAIT  | write granted, waiting for rvalid, then advance
// DONE     | one-cycle completion pulse
module tinyodin_obi_loader
    import tinyodin_loader_pkg::*;
#(
    parameter type         req_t = logic,
    parameter type         rsp_t = logic,
    parameter int unsigned LEN_W = LEN_W_DEFAULT
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             start_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    output req_t             loader_master_req_o,
    input  rsp_t             loader_master_resp_i,
    output logic             busy_o,
    output logic             intr_loader_done_o
);

    loader_state_e state, state_next;
    obi_req_t      req_s;
    obi_rsp_t      rsp;
    logic [31:0]   rd_buf;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic          load;
    logic          step;
    logic          buf_load;
    logic          last_word;
    logic          abort_hit;

    // req_t/rsp_t are expected to share the bit layout of obi_req_t/obi_rsp_t.
    assign rsp                 = obi_rsp_t'(loader_master_resp_i);
    assign loader_master_req_o = req_t'(req_s);

`ifdef TINYODIN_LOADER_ABORT_EN
    logic abort_q;

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            abort_q <= 1'b0;
        end else if (state == ST_IDLE) begin
            abort_q <= 1'b0;
        end else if (abort_i) begin
            abort_q <= 1'b1;
        end
    end

    assign abort_hit = abort_i | abort_q;
`else
    logic unused_abort;
    assign unused_abort = abort_i;
    assign abort_hit    = 1'b0;
`endif

    tinyodin_loader_ctr #(.LEN_W(LEN_W)) u_ctr (
        .clk       (CLK),
        .rst_n     (RSTN),
        .load      (load),
        .step      (step),
        .src_base  (src_addr_i),
        .dst_base  (dst_addr_i),
        .len       (len_i),
        .src_addr  (src_addr),
        .dst_addr  (dst_addr),
        .last_word (last_word)
    );

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state  <= ST_IDLE;
            rd_buf <= '0;
        end else begin
            state <= state_next;
            if (buf_load) begin
                rd_buf <= rsp.rdata;
            end
        end
    end

    always_comb begin
        state_next = state;
        req_s      = '0;
        load       = 1'b0;
        step       = 1'b0;
        buf_load   = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (start_i) begin
                    load       = 1'b1;
                    state_next = (len_i == '0) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_RD_REQ: begin
                req_s.req  = 1'b1;
                req_s.be   = BE_FULL;
                req_s.addr = src_addr;
                if (rsp.gnt) begin
                    state_next = ST_RD_WAIT;
                end else if (abort_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_RD_WAIT: begin
                if (rsp.rvalid) begin
                    buf_load   = 1'b1;
                    state_next = abort_hit ? ST_DONE : ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                req_s.req   = 1'b1;
                req_s.we    = 1'b1;
                req_s.be    = BE_FULL;
                req_s.addr  = dst_addr;
                req_s.wdata = rd_buf;
                if (rsp.gnt) begin
                    state_next = ST_WR_WAIT;
                end else if (abort_hit) begin
                    state_next = ST_DONE;
                end
            end
            ST_WR_WAIT: begin
                if (rsp.rvalid) begin
                    step       = 1'b1;
                    state_next = (last_word || abort_hit) ? ST_DONE : ST_RD_REQ;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign busy_o             = (state != ST_IDLE) && (state != ST_DONE);
    assign intr_loader_done_o = (state == ST_DONE);

endmodule

// File: tb/tb_tinyodin_obi_loader.sv
// Bench for tinyodin_obi_loader: randomized OBI slave plus a transaction-list reference model.
// Define TINYODIN_LOADER_ABORT_EN to also exercise the abort path.
module tb_tinyodin_obi_loader;
    import tinyodin_loader_pkg::*;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } txn_t;

    logic        CLK = 1'b0;
    logic        RSTN;
    logic        start;
    logic        abort;
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
    obi_req_t    mreq;
    obi_rsp_t    mrsp;
    logic        busy;
    logic        done;

    int          tests_run    = 0;
    int          tests_failed = 0;
    txn_t        exp_q[$];
    logic [31:0] seed;

    // slave configuration (written by the main process only)
    int          gnt_mode   = 0;
    int          rv_mode    = 0;
    bit          spur_en    = 1'b0;
    int          slow_wr_at = -1;
    int          flush_req  = 0;

    // slave state (written by the slave process only)
    int          rd_grants = 0;
    int          wr_grants = 0;
    int          slow_hold = 0;
    int          done_seen = 0;

    tinyodin_obi_loader #(
        .req_t (obi_req_t),
        .rsp_t (obi_rsp_t),
        .LEN_W (16)
    ) dut (
        .CLK                  (CLK),
        .RSTN                 (RSTN),
        .start_i              (start),
        .src_addr_i           (src),
        .dst_addr_i           (dst),
        .len_i                (len),
        .abort_i              (abort),
        .loader_master_req_o  (mreq),
        .loader_master_resp_i (mrsp),
        .busy_o               (busy),
        .intr_loader_done_o   (done)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ seed;
    endfunction

    // Reference model: word i reads src+4i then writes dst+4i with that word.
    task automatic build_expect(input logic [31:0] s, input logic [31:0] d, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            logic [31:0] ra;
            logic [31:0] wa;
            ra = s + 32'(4 * i);
            wa = d + 32'(4 * i);
            exp_q.push_back('{we: 1'b0, addr: ra, wdata: 32'h0});
            exp_q.push_back('{we: 1'b1, addr: wa, wdata: mem_word(ra)});
        end
    endtask

    // OBI slave: acts on the falling edge, checks each granted transaction against exp_q.
    initial begin
        bit       pending;
        bit       holding;
        bit       slow_active;
        int       gnt_cnt;
        int       rv_cnt;
        int       hold_cycles;
        int       flush_ack;
        obi_req_t held;
        txn_t     t;
        pending = 0; holding = 0; slow_active = 0;
        gnt_cnt = 0; rv_cnt = 0; hold_cycles = 0; flush_ack = 0;
        held = '0;
        mrsp = '0;
        forever begin
            @(negedge CLK);
            mrsp.gnt    = 1'b0;
            mrsp.rvalid = 1'b0;
            if (flush_ack != flush_req) begin
                flush_ack = flush_req;
                pending = 0; holding = 0; slow_active = 0;
            end
            if (!mreq.req) holding = 0;
            if (pending) begin
                if (rv_cnt == 0) begin
                    mrsp.rvalid = 1'b1;
                    mrsp.rdata  = held.we ? $urandom() : mem_word(held.addr);
                    pending     = 0;
                end else begin
                    rv_cnt--;
                end
            end else if (mreq.req) begin
                if (!holding) begin
                    holding     = 1;
                    held        = mreq;
                    hold_cycles = 0;
                    gnt_cnt     = (gnt_mode == 0) ? 0 : int'($urandom_range(0, 3));
                    if (mreq.we && (wr_grants + 1 == slow_wr_at)) begin
                        gnt_cnt     = 5;
                        slow_active = 1;
                    end
                end else begin
                    hold_cycles++;
                    check_eq("hold_we", mreq.we, held.we);
                    check_eq("hold_addr", mreq.addr, held.addr);
                    check_eq("hold_wdata", mreq.wdata, held.wdata);
                    check_eq("hold_be", mreq.be, held.be);
                end
                if (gnt_cnt == 0) begin
                    mrsp.gnt = 1'b1;
                    holding  = 0;
                    pending  = 1;
                    rv_cnt   = (rv_mode == 0) ? 0 : (rv_mode == 1) ? int'($urandom_range(0, 2)) : 2;
                    if (held.we) wr_grants++;
                    else         rd_grants++;
                    if (slow_active && held.we) begin
                        slow_hold   = hold_cycles;
                        slow_active = 0;
                    end
                    check_eq("txn_avail", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        t = exp_q.pop_front();
                        check_eq("txn_we", held.we, t.we);
                        check_eq("txn_addr", held.addr, t.addr);
                        check_eq("txn_be", held.be, 4'hF);
                        if (t.we) check_eq("txn_wdata", held.wdata, t.wdata);
                    end
                end else begin
                    gnt_cnt--;
                end
            end else if (spur_en && $urandom_range(0, 3) == 0) begin
                mrsp.rvalid = 1'b1;
                mrsp.rdata  = $urandom();
            end
        end
    end

    task automatic tick();
        @(negedge CLK);
        #1;
        if (done) begin
            done_seen++;
            check_eq("done_busy_low", busy, 0);
        end
    endtask

    task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int n);
        src = s; dst = d; len = 16'(n); start = 1'b1;
        tick();
        start = 1'b0; src = $urandom(); dst = $urandom(); len = 16'($urandom());
    endtask

    // exp_lat > 0 checks the cycle (counted from the start edge) on which done appears.
    task automatic run_transfer(input logic [31:0] s, input logic [31:0] d, input int n,
                                input bit mid_start, input int exp_lat);
        int d0;
        int cyc;
        build_expect(s, d, n);
        d0 = done_seen;
        pulse_start(s, d, n);
        cyc = 1;
        if (n == 0) check_eq("len0_no_req", mreq.req, 0);
        else        check_eq("busy_after_start", busy, 1);
        while (done_seen == d0 && cyc < 600) begin
            if (mid_start && cyc == 2) begin
                start = 1'b1; len = 16'($urandom_range(1, 9)); src = $urandom(); dst = $urandom();
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        check_eq("done_count", done_seen - d0, 1);
        if (exp_lat > 0) check_eq("done_latency", cyc, exp_lat);
        tick();
        check_eq("done_one_cycle", done, 0);
        check_eq("idle_busy", busy, 0);
        check_eq("txn_missing", exp_q.size(), 0);
    endtask

    task automatic reset_mid_transfer();
        int w0;
        int d0;
        int cyc;
        build_expect(32'h5000, 32'h2000_0800, 4);
        w0 = wr_grants;
        pulse_start(32'h5000, 32'h2000_0800, 4);
        cyc = 0;
        while (wr_grants - w0 < 2 && cyc < 200) begin
            tick();
            cyc++;
        end
        check_eq("rst_reach_word2", wr_grants - w0, 2);
        tick();
        RSTN = 1'b0;
        #1;
        check_eq("midrst_req", mreq.req, 0);
        check_eq("midrst_we", mreq.we, 0);
        check_eq("midrst_be", mreq.be, 0);
        check_eq("midrst_addr", mreq.addr, 0);
        check_eq("midrst_wdata", mreq.wdata, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_done", done, 0);
        exp_q.delete();
        flush_req++;
        d0 = done_seen;
        repeat (2) tick();
        RSTN = 1'b1;
        repeat (8) tick();
        check_eq("midrst_no_done", done_seen - d0, 0);
        check_eq("midrst_no_req", mreq.req, 0);
    endtask

`ifdef TINYODIN_LOADER_ABORT_EN
    task automatic abort_in_rd_wait();
        int r0;
        int w0;
        int d0;
        int cyc;
        gnt_mode = 0; rv_mode = 2; spur_en = 0;
        exp_q.delete();
        exp_q.push_back('{we: 1'b0, addr: 32'h7000, wdata: 32'h0});
        r0 = rd_grants; w0 = wr_grants; d0 = done_seen;
        pulse_start(32'h7000, 32'h2000_0C00, 8);
        cyc = 0;
        while (rd_grants - r0 < 1 && cyc < 50) begin
            tick();
            cyc++;
        end
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc = 0;
        while (done_seen == d0 && cyc < 50) begin
            tick();
            cyc++;
        end
        check_eq("abort_done", done_seen - d0, 1);
        check_eq("abort_no_write", wr_grants - w0, 0);
        check_eq("abort_one_read", rd_grants - r0, 1);
        tick();
        check_eq("abort_busy", busy, 0);
        check_eq("abort_txn_left", exp_q.size(), 0);
    endtask
`endif

    initial begin
        seed  = $urandom();
        RSTN  = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        src   = '0;
        dst   = '0;
        len   = '0;
        repeat (2) tick();
        check_eq("rst_req", mreq.req, 0);
        check_eq("rst_we", mreq.we, 0);
        check_eq("rst_be", mreq.be, 0);
        check_eq("rst_addr", mreq.addr, 0);
        check_eq("rst_wdata", mreq.wdata, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        RSTN = 1'b1;
        tick();

        gnt_mode = 0; rv_mode = 0; spur_en = 0;
        run_transfer(32'h0000_1000, 32'h2000_0100, 3, 1'b0, 13);
        run_transfer(32'h0000_2000, 32'h2000_0200, 0, 1'b0, 1);

        slow_wr_at = wr_grants + 1;
        run_transfer(32'h0000_0040, 32'h2000_0000, 2, 1'b0, 0);
        slow_wr_at = -1;
        check_eq("slow_wr_hold", slow_hold, 5);

        run_transfer(32'h0000_3000, 32'h2000_0400, 4, 1'b1, 17);

        reset_mid_transfer();
        run_transfer(32'h0000_6000, 32'h2000_0A00, 2, 1'b0, 9);

        gnt_mode = 1; rv_mode = 1; spur_en = 1;
        run_transfer(32'hFFFF_FFF8, 32'hFFFF_FFFC, 3, 1'b0, 0);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] s;
            logic [31:0] d;
            s = $urandom() & 32'hFFFF_FFFC;
            d = $urandom() & 32'hFFFF_FFFC;
            run_transfer(s, d, int'($urandom_range(1, 6)), k[0], 0);
        end

`ifdef TINYODIN_LOADER_ABORT_EN
        abort_in_rd_wait();
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
